// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO: configurable data width, parity, stop bits and baud divisor.
// Producers may burst writes while TxD_ready is high; frames go out back to back with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_BITS-1:0]              TxD_data,
  input  logic                              TxD_start,
  output logic                              TxD_ready,
  output logic                              TxD,
  output logic                              TxD_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {sIdle, sStart, sData, sPar, sStop} state_t;

  state_t                state, nextState;
  logic [1:0]            rstPipe;
  logic                  rstInt;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         wrPtr, rdPtr;
  logic [DATA_BITS-1:0]  head, shReg;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bitIdx;
  logic                  tick, pop, wrEn, empty, parBit, txdReg, txdNext;

  // Assert asynchronously, release two clocks after reset drops.
  always_ff @(posedge clk or posedge reset)
    if (reset) rstPipe <= 2'b11;
    else       rstPipe <= {rstPipe[0], 1'b0};
  assign rstInt = rstPipe[1];

  assign empty     = (fifo_count == '0);
  assign TxD_ready = (fifo_count != NW'(FIFO_DEPTH));
  assign wrEn      = TxD_start & TxD_ready;
  assign head      = mem[rdPtr];
  assign tick      = (cnt == LAST);
  assign TxD       = txdReg;
  assign TxD_busy  = (state != sIdle) | ~empty;

  always_ff @(posedge clk)
    if (wrEn) mem[wrPtr] <= TxD_data;

  always_ff @(posedge clk or posedge rstInt)
    if (rstInt) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({wrEn, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      overflow <= TxD_start & ~TxD_ready;
    end

  always_ff @(posedge clk or posedge rstInt)
    if (rstInt) state <= sIdle;
    else        state <= nextState;

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    case (state)
      sIdle:  if (!empty) begin
                pop       = 1'b1;
                nextState = sStart;
              end
      sStart: if (tick) nextState = sData;
      sData:  if (tick && bitIdx == BW'(DATA_BITS - 1))
                nextState = (PARITY != 0) ? sPar : sStop;
      sPar:   if (tick) nextState = sStop;
      sStop:  if (tick && bitIdx == BW'(STOP_BITS - 1)) begin
                if (!empty) begin
                  pop       = 1'b1;
                  nextState = sStart;
                end else begin
                  nextState = sIdle;
                end
              end
      default: nextState = sIdle;
    endcase
  end

  // Line level is computed for the state being entered so TxD lands on the same edge.
  always_comb begin
    txdNext = 1'b1;
    case (nextState)
      sStart:  txdNext = 1'b0;
      sData:   txdNext = (state == sData && tick) ? shReg[1] : shReg[0];
      sPar:    txdNext = parBit;
      default: txdNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rstInt)
    if (rstInt) begin
      cnt    <= '0;
      bitIdx <= '0;
      shReg  <= '0;
      parBit <= 1'b0;
      txdReg <= 1'b1;
    end else begin
      txdReg <= txdNext;
      if (nextState != state || state == sIdle || tick) cnt <= '0;
      else                                              cnt <= cnt + 1'b1;
      if (nextState != state) bitIdx <= '0;
      else if (tick)          bitIdx <= bitIdx + 1'b1;
      if (pop) begin
        shReg  <= head;
        parBit <= (PARITY == 1) ? ~^head : ^head;
      end else if (state == sData && tick) begin
        shReg <= shReg >> 1;
      end
    end

endmodule
